// File: rtl/xcvr_bus_ctrl.sv
// xcvr_bus_ctrl
//   Sequencing controller and two-way arbiter for a single 8-bit octal bus
//   transceiver (dir / g_n pair) sitting between the local A-side bus and the
//   system B-side bus. A CPU and a DMA engine share the transceiver. Each
//   transfer runs IDLE -> SETUP -> ACTIVE -> TURN -> IDLE. The direction only
//   changes while the transceiver has already been disabled for a full cycle,
//   so the two sides can never drive the bus at the same time.
//
// Ports
//   clk        system clock, rising edge
//   reset_n    asynchronous active-low reset
//   cpu_req    CPU transfer request (held until cpu_done)
//   cpu_wr     CPU direction, 1 = write (A->B), 0 = read (B->A)
//   cpu_gnt    CPU owns the transceiver
//   cpu_done   one-cycle completion pulse to the CPU
//   dma_req    DMA transfer request
//   dma_wr     DMA direction, same encoding as cpu_wr
//   dma_gnt    DMA owns the transceiver
//   dma_done   one-cycle completion pulse to the DMA
//   rdy        system bus ready
//   dir        transceiver direction, 1 = A->B, 0 = B->A
//   g_n        transceiver enable, active low
//   busy       controller is not idle
//   err        one-cycle timeout pulse, coincident with the done pulse
module xcvr_bus_ctrl #(
  parameter int MIN_ACTIVE  = 2,   // minimum g_n-low cycles per transfer (1..15)
  parameter int TURN_CYCLES = 1,   // forced g_n-high cycles after a transfer (1..7)
  parameter int TIMEOUT     = 255  // ACTIVE cycle limit before abort (> MIN_ACTIVE, <= 255)
) (
  input  logic clk,
  input  logic reset_n,
  input  logic cpu_req,
  input  logic cpu_wr,
  output logic cpu_gnt,
  output logic cpu_done,
  input  logic dma_req,
  input  logic dma_wr,
  output logic dma_gnt,
  output logic dma_done,
  input  logic rdy,
  output logic dir,
  output logic g_n,
  output logic busy,
  output logic err
);

  localparam logic [7:0] MIN_C     = 8'(MIN_ACTIVE);
  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);
  localparam logic [2:0] TURN_C    = 3'(TURN_CYCLES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACTIVE = 2'd2,
    TURN   = 2'd3
  } state_t;

  state_t     state_reg, state_next;
  logic       owner_dma_reg, owner_dma_next;  // owner of the current transfer
  logic       wr_reg, wr_next;                // latched direction of the owner
  logic       last_dma_reg, last_dma_next;    // owner of the most recent transfer
  logic [7:0] act_cnt_reg, act_cnt_next;
  logic [2:0] turn_cnt_reg, turn_cnt_next;

  logic cpu_gnt_next, dma_gnt_next, cpu_done_next, dma_done_next;
  logic dir_next, g_n_next, busy_next, err_next;
  logic done_any, pick_dma;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      owner_dma_reg <= 1'b0;
      wr_reg        <= 1'b0;
      last_dma_reg  <= 1'b0;
      act_cnt_reg   <= 8'd0;
      turn_cnt_reg  <= 3'd0;
      cpu_gnt       <= 1'b0;
      dma_gnt       <= 1'b0;
      cpu_done      <= 1'b0;
      dma_done      <= 1'b0;
      dir           <= 1'b0;
      g_n           <= 1'b1;
      busy          <= 1'b0;
      err           <= 1'b0;
    end else begin
      state_reg     <= state_next;
      owner_dma_reg <= owner_dma_next;
      wr_reg        <= wr_next;
      last_dma_reg  <= last_dma_next;
      act_cnt_reg   <= act_cnt_next;
      turn_cnt_reg  <= turn_cnt_next;
      cpu_gnt       <= cpu_gnt_next;
      dma_gnt       <= dma_gnt_next;
      cpu_done      <= cpu_done_next;
      dma_done      <= dma_done_next;
      dir           <= dir_next;
      g_n           <= g_n_next;
      busy          <= busy_next;
      err           <= err_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    owner_dma_next = owner_dma_reg;
    wr_next        = wr_reg;
    last_dma_next  = last_dma_reg;
    act_cnt_next   = act_cnt_reg;
    turn_cnt_next  = turn_cnt_reg;
    done_any       = 1'b0;
    err_next       = 1'b0;
    pick_dma       = 1'b0;

    case (state_reg)
      IDLE: begin
        act_cnt_next  = 8'd0;
        turn_cnt_next = 3'd0;
        if (cpu_req || dma_req) begin
          // DMA has priority except right after its own transfer when the
          // CPU is waiting, which makes contention alternate.
          pick_dma       = dma_req && !(last_dma_reg && cpu_req);
          owner_dma_next = pick_dma;
          wr_next        = pick_dma ? dma_wr : cpu_wr;
          last_dma_next  = pick_dma;
          state_next     = SETUP;
        end
      end
      SETUP: begin
        act_cnt_next = 8'd1;
        state_next   = ACTIVE;
      end
      ACTIVE: begin
        if (act_cnt_reg >= MIN_C && rdy) begin
          done_any      = 1'b1;
          turn_cnt_next = 3'd1;
          state_next    = TURN;
        end else if (act_cnt_reg == TIMEOUT_C) begin
          done_any      = 1'b1;
          err_next      = 1'b1;
          turn_cnt_next = 3'd1;
          state_next    = TURN;
        end else begin
          act_cnt_next = act_cnt_reg + 8'd1;
        end
      end
      TURN: begin
        if (turn_cnt_reg == TURN_C) begin
          state_next = IDLE;
        end else begin
          turn_cnt_next = turn_cnt_reg + 3'd1;
        end
      end
      default: state_next = IDLE;
    endcase

    // Outputs are decoded from the next state and registered, so they line
    // up cycle-for-cycle with the state they describe.
    busy_next     = (state_next != IDLE);
    g_n_next      = (state_next != ACTIVE);
    // wr_next only changes on the IDLE->SETUP edge, where g_n has already
    // been high for the TURN and IDLE cycles.
    dir_next      = wr_next;
    cpu_gnt_next  = busy_next && !owner_dma_next;
    dma_gnt_next  = busy_next && owner_dma_next;
    cpu_done_next = done_any && !owner_dma_next;
    dma_done_next = done_any && owner_dma_next;
  end

endmodule

// File: tb/tb_xcvr_bus_ctrl.sv
// Testbench for xcvr_bus_ctrl: directed stimulus, a transfer-timeline model
// checked against the DUT on every negative clock edge, and a set of literal
// expectations for the headline scenarios.
module tb_xcvr_bus_ctrl;

  localparam int MIN_A = 2;
  localparam int TURN  = 1;
  localparam int TOUT  = 8;

  logic clk = 1'b0;
  logic reset_n, cpu_req, cpu_wr, dma_req, dma_wr, rdy;
  logic cpu_gnt, cpu_done, dma_gnt, dma_done, dir, g_n, busy, err;

  xcvr_bus_ctrl #(.MIN_ACTIVE(MIN_A), .TURN_CYCLES(TURN), .TIMEOUT(TOUT)) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_gnt(cpu_gnt), .cpu_done(cpu_done),
    .dma_req(dma_req), .dma_wr(dma_wr), .dma_gnt(dma_gnt), .dma_done(dma_done),
    .rdy(rdy), .dir(dir), .g_n(g_n), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic bound_fail(input string name);
    n_checks++;
    $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
  endtask

  // ---------------- transfer-timeline model ----------------
  // A transfer is described by the cycle its SETUP occupies, its ACTIVE
  // length (0 until rdy/timeout decides it) and whether it aborted.
  bit xf, m_own_dma, m_wr, m_abort, last_dma, e_dir;
  int t_setup, act_len;

  // monitor state
  logic prev_g_n = 1'b1, prev_dir = 1'b0, prev_cg = 1'b0, prev_dg = 1'b0;
  int low_run = 0, high_run = 0, last_low = 0, min_high = 1000;
  int cpu_done_cnt = 0;
  bit gq[$];  // grant order, 1 = DMA

  always @(negedge clk) begin
    int ph, off;
    if (!reset_n) begin
      xf = 0; last_dma = 0; e_dir = 0; m_abort = 0; act_len = 0;
    end
    ph = 0; off = cyc - t_setup;
    if (xf) begin
      if (off == 0) ph = 1;
      else if (act_len == 0 || off <= act_len) ph = 2;
      else if (off <= act_len + TURN) ph = 3;
      else xf = 0;
    end
    if (ph != 0) e_dir = m_wr;

    chk("g_n",      g_n,      (ph != 2));
    chk("busy",     busy,     (ph != 0));
    chk("dir",      dir,      e_dir);
    chk("cpu_gnt",  cpu_gnt,  (ph != 0) && !m_own_dma);
    chk("dma_gnt",  dma_gnt,  (ph != 0) && m_own_dma);
    chk("cpu_done", cpu_done, (ph == 3) && (off == act_len + 1) && !m_own_dma);
    chk("dma_done", dma_done, (ph == 3) && (off == act_len + 1) && m_own_dma);
    chk("err",      err,      (ph == 3) && (off == act_len + 1) && m_abort);

    // Direction may only move after g_n has been high two cycles running.
    if (reset_n && dir !== prev_dir) chk("dir_turnaround", {31'd0, g_n && prev_g_n}, 1);

    // Run-length and grant-order bookkeeping.
    if (g_n == 1'b0) begin
      if (prev_g_n && high_run < min_high) min_high = high_run;
      low_run++; high_run = 0;
    end else begin
      if (!prev_g_n) last_low = low_run;
      high_run++; low_run = 0;
    end
    if (cpu_gnt && !prev_cg) gq.push_back(1'b0);
    if (dma_gnt && !prev_dg) gq.push_back(1'b1);
    if (cpu_done) cpu_done_cnt++;
    prev_g_n = g_n; prev_dir = dir; prev_cg = cpu_gnt; prev_dg = dma_gnt;

    // Advance the model with the inputs the DUT samples at the next edge.
    if (reset_n) begin
      if (ph == 0 && (cpu_req || dma_req)) begin
        m_own_dma = dma_req && !(last_dma && cpu_req);
        m_wr      = m_own_dma ? dma_wr : cpu_wr;
        last_dma  = m_own_dma;
        xf = 1; t_setup = cyc + 1; act_len = 0; m_abort = 0;
      end else if (ph == 2 && act_len == 0) begin
        if (off >= MIN_A && rdy) act_len = off;
        else if (off == TOUT) begin act_len = off; m_abort = 1; end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic wait_done(input bit is_dma, input bit drop, output int dcyc, output logic derr);
    dcyc = -1; derr = 1'bx;
    for (int i = 0; i < 300; i++) begin
      step();
      if (is_dma ? dma_done : cpu_done) begin
        dcyc = cyc; derr = err;
        if (drop) begin if (is_dma) dma_req = 0; else cpu_req = 0; end
        return;
      end
    end
    bound_fail(is_dma ? "dma_done_wait" : "cpu_done_wait");
  endtask

  task automatic wait_active(input string name);
    for (int i = 0; i < 50; i++) begin
      step();
      if (g_n == 1'b0) return;
    end
    bound_fail(name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rc, dc, nd, snap;
    logic e;
    bit exp_order[4];
    exp_order = '{1'b1, 1'b0, 1'b1, 1'b0};

    reset_n = 0; cpu_req = 0; cpu_wr = 0; dma_req = 0; dma_wr = 0; rdy = 0;
    step();
    chk("reset_g_n", g_n, 1); chk("reset_busy", busy, 0); chk("reset_dir", dir, 0);
    step(); step();
    reset_n = 1;
    step();

    // CPU write, rdy high
    rdy = 1; cpu_wr = 1; cpu_req = 1; rc = cyc;
    wait_done(0, 1, dc, e);
    chk("cpu_wr_done_latency", dc - rc, 4);
    chk("cpu_wr_err", e, 0);
    step();
    chk("cpu_wr_low_len", last_low, 2);
    chk("cpu_wr_idle_gnt", cpu_gnt, 0);
    $display("txn cpu write: done at +%0d, g_n low %0d cycles", dc - rc, last_low);
    step(); step();

    // DMA read, rdy low for five ACTIVE cycles
    rdy = 0; dma_wr = 0; dma_req = 1;
    wait_active("dma_rd_active");
    for (int i = 0; i < 5; i++) step();
    rdy = 1;
    wait_done(1, 1, dc, e);
    chk("dma_rd_err", e, 0);
    step();
    chk("dma_rd_low_len", last_low, 6);
    chk("dma_rd_dir", dir, 0);
    $display("txn dma read: g_n low %0d cycles, err %0d", last_low, e);
    step(); step();

    // Timeout
    rdy = 0; cpu_wr = 0; cpu_req = 1;
    wait_done(0, 1, dc, e);
    chk("timeout_err", e, 1);
    step();
    chk("timeout_low_len", last_low, 8);
    rdy = 1;
    $display("txn cpu timeout: g_n low %0d cycles, err %0d", last_low, e);
    step(); step();

    // Contention: last owner was CPU, so DMA goes first
    gq.delete(); min_high = 1000;
    dma_wr = 1; cpu_wr = 0; dma_req = 1; cpu_req = 1; nd = 0;
    for (int i = 0; i < 200 && nd < 4; i++) begin
      step();
      if (cpu_done || dma_done) nd++;
    end
    dma_req = 0; cpu_req = 0;
    if (nd < 4) bound_fail("contention_dones");
    step(); step(); step();
    chk("contention_grants", gq.size(), 4);
    for (int i = 0; i < 4 && i < gq.size(); i++) begin
      chk($sformatf("grant_order[%0d]", i), gq[i], exp_order[i]);
      $display("txn contention %0d: owner %s", i, gq[i] ? "DMA" : "CPU");
    end
    chk("contention_min_gap", min_high, 3);

    // Early request drop during ACTIVE
    snap = cpu_done_cnt;
    rdy = 0; cpu_wr = 1; cpu_req = 1;
    wait_active("drop_active");
    step(); cpu_req = 0;
    step(); step(); rdy = 1;
    wait_done(0, 0, dc, e);
    for (int i = 0; i < 6; i++) step();
    chk("drop_done_count", cpu_done_cnt - snap, 1);
    chk("drop_gnt_after", cpu_gnt, 0);
    chk("drop_busy_after", busy, 0);
    $display("txn early drop: %0d done pulse(s)", cpu_done_cnt - snap);

    // Reset in the middle of ACTIVE
    rdy = 0; cpu_wr = 0; cpu_req = 1;
    wait_active("rst_active");
    step();
    #1 reset_n = 0;
    #1;
    chk("rst_g_n_async", g_n, 1);
    chk("rst_gnt_async", cpu_gnt, 0);
    chk("rst_busy_async", busy, 0);
    cpu_req = 0; snap = cpu_done_cnt;
    step(); step();
    reset_n = 1;
    chk("rst_no_done", cpu_done_cnt - snap, 0);
    rdy = 1; cpu_req = 1;
    step();
    chk("rst_first_gnt", cpu_gnt, 1);
    chk("rst_first_g_n", g_n, 1);
    wait_done(0, 1, dc, e);
    step(); step(); step();
    $display("txn reset mid-active: re-request completed at cycle %0d", dc);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/xcvr_bus_ctrl.md
Name: xcvr_bus_ctrl

Overview:
- Sequencing controller and two-way arbiter for one 8-bit octal bus transceiver (dir, g_n control pair) between the local data bus (A side) and the system data bus (B side).
- Shares the transceiver between a CPU requester and a DMA requester.
- Generates enable and direction with guaranteed turnaround, so both sides never drive the bus at once.
- Stretches each cycle with the system rdy line and aborts on timeout.

Parameters:
- MIN_ACTIVE, 2, minimum number of cycles g_n stays low per transfer (1..15).
- TURN_CYCLES, 1, number of cycles g_n is forced high after each transfer (1..7).
- TIMEOUT, 255, maximum cycles in ACTIVE before abort (must be greater than MIN_ACTIVE, up to 255).

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset_n  input  1  asynchronous active-low reset.
- cpu_req  input  1  CPU requests a transfer; held high until cpu_done.
- cpu_wr  input  1  CPU direction: 1 = write (A->B), 0 = read (B->A).
- cpu_gnt  output  1  CPU owns the transceiver.
- cpu_done  output  1  one-cycle completion pulse to the CPU.
- dma_req  input  1  DMA requests a transfer.
- dma_wr  input  1  DMA direction, same encoding as cpu_wr.
- dma_gnt  output  1  DMA owns the transceiver.
- dma_done  output  1  one-cycle completion pulse to the DMA.
- rdy  input  1  system bus ready, synchronous to clk.
- dir  output  1  transceiver direction: 1 = A->B, 0 = B->A.
- g_n  output  1  transceiver enable, active low.
- busy  output  1  high in any state other than IDLE.
- err  output  1  one-cycle timeout pulse, coincident with the done pulse.

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous and active-low. All outputs are registered.
- Reset values:
  - g_n = 1, dir = 0.
  - cpu_gnt = dma_gnt = 0, cpu_done = dma_done = 0.
  - busy = 0, err = 0.
  - State = IDLE, counters = 0, last_owner = CPU.
- Reset asserted mid-transfer: g_n goes high immediately (asynchronously). No done pulse is issued. The aborted requester must re-request.
- States: IDLE -> SETUP -> ACTIVE -> TURN -> IDLE.
- IDLE:
  - g_n = 1; grants low.
  - If any request is high, latch the owner and its wr bit, then go to SETUP.
- Arbitration (IDLE only):
  - dma_req wins, unless last_owner = DMA and cpu_req = 1; in that case the CPU wins.
  - Under continuous contention, ownership therefore alternates DMA, CPU, DMA, ...
  - last_owner updates on entry to SETUP.
- SETUP (exactly 1 cycle):
  - Owner's gnt = 1; dir = latched wr; g_n = 1.
- ACTIVE:
  - g_n = 0; dir held constant.
  - The cycle counter starts at 1 on the first ACTIVE cycle.
  - Exit at the end of the first cycle with counter >= MIN_ACTIVE and rdy = 1 (normal completion).
  - Also exit when counter == TIMEOUT with rdy still low (abort).
  - rdy is ignored before MIN_ACTIVE is reached.
  - Read data is valid on the A side during ACTIVE. The requester captures it on the exit edge.
- TURN (TURN_CYCLES cycles):
  - g_n = 1; dir held; gnt held.
  - The owner's done pulses in the first TURN cycle only. err pulses with it on abort.
  - After the last TURN cycle, go to IDLE, where gnt drops.
- Direction invariant: dir changes only while g_n = 1 and g_n was also 1 in the previous cycle. Between two transfers g_n stays high for at least TURN_CYCLES + 2 cycles.
- Request behaviour:
  - A requester dropping req mid-transfer does not abort; the transfer and its done pulse complete.
  - Requests and wr changes during SETUP, ACTIVE or TURN are ignored until the next IDLE.
- Both requests arriving in the same IDLE cycle: the arbitration rule decides; the loser stays pending.
- Invariants: cpu_gnt and dma_gnt are never high together, and at most one done is high per cycle.

Test Plan:
- Reset and idle check:
  - Stimulus: reset_n low mid-ACTIVE.
  - Response: g_n = 1 within the same cycle. All outputs at reset values, no done pulse. First request after release reaches SETUP 1 cycle after IDLE sampling.
- CPU write, rdy tied high, defaults:
  - Response: SETUP at cycle 1 (dir = 1, g_n = 1), ACTIVE cycles 2-3 (g_n = 0), TURN at cycle 4 with cpu_done = 1, IDLE at cycle 5 with cpu_gnt = 0.
- DMA read with rdy low for 5 ACTIVE cycles, then high:
  - Response: dir = 0, g_n low for exactly 6 cycles, dma_done one cycle, err = 0.
- Timeout with TIMEOUT = 8, rdy held low:
  - Response: g_n low exactly 8 cycles, then cpu_done and err both pulse for one cycle.
- Contention, cpu_req and dma_req both held high for 4 transfers:
  - Response: grant order DMA, CPU, DMA, CPU. Grants never overlap.
  - On every DMA write -> CPU read switch, dir changes only with g_n high for at least 3 consecutive cycles.
- Early request drop: cpu_req drops during ACTIVE.
  - Response: transfer completes, cpu_done still pulses once, controller returns to IDLE with no further grant.
